complex_split: RTL



---
 rtl/complex_split.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/complex_split.sv
// complex_split: splits an sc16 {I,Q} stream into two independent real streams,
// each with its own data/header FIFO pair and port-specific CHDR SID fields.

module complex_split_fifo #(
    parameter int WIDTH = 33,
    parameter int SIZE  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int DEPTH = 1 << SIZE;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [SIZE:0]    wr_ptr;
    logic [SIZE:0]    rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[SIZE-1:0]] <= push_data;
    end

    // The extra pointer bit tells a full ring from an empty one after wrap-around.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[SIZE] != rd_ptr[SIZE]) &&
                   (wr_ptr[SIZE-1:0] == rd_ptr[SIZE-1:0]);
    // Storage is not reset, so an empty FIFO presents zeros instead of stale words.
    assign head  = empty ? '0 : mem[rd_ptr[SIZE-1:0]];
endmodule

module complex_split #(
    parameter int DATA_FIFO_SIZE = 5,
    parameter int HDR_FIFO_SIZE  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [15:0]  src_sid0,
    input  logic [15:0]  next_dst_sid0,
    input  logic [15:0]  src_sid1,
    input  logic [15:0]  next_dst_sid1,
    input  logic [31:0]  i_tdata,
    input  logic [127:0] i_tuser,
    input  logic         i_tlast,
    input  logic         i_tvalid,
    output logic         i_tready,
    output logic [31:0]  o0_tdata,
    output logic [127:0] o0_tuser,
    output logic         o0_tlast,
    output logic         o0_tvalid,
    input  logic         o0_tready,
    output logic [31:0]  o1_tdata,
    output logic [127:0] o1_tuser,
    output logic         o1_tlast,
    output logic         o1_tvalid,
    input  logic         o1_tready
);
    // Handshakes: a beat moves on a rising edge where valid & ready are both high;
    // valid never waits on ready, and i_tready depends only on registered FIFO state.

    logic        sop;
    logic        run;
    logic        in_push;
    logic        hdr_push;
    logic [95:0] hdr_word;

    logic [32:0] d0_head, d1_head;
    logic [95:0] h0_head, h1_head;
    logic        d0_empty, d0_full, d1_empty, d1_full;
    logic        h0_empty, h0_full, h1_empty, h1_full;
    logic        d0_pop, d1_pop, h0_pop, h1_pop;
    logic        unused_tuser;

    // run holds i_tready low through reset and rises on the first edge after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
            sop <= 1'b1;
        end else begin
            run <= 1'b1;
            if (in_push) sop <= i_tlast;
        end
    end

    assign i_tready = run && !d0_full && !d1_full && (!sop || (!h0_full && !h1_full));
    assign in_push  = i_tvalid && i_tready;
    assign hdr_push = in_push && sop;
    assign hdr_word = {i_tuser[127:96], i_tuser[63:0]};
    assign unused_tuser = ^i_tuser[95:64];

    assign d0_pop = o0_tvalid && o0_tready;
    assign d1_pop = o1_tvalid && o1_tready;
    // A packet's header retires together with its tlast beat.
    assign h0_pop = d0_pop && d0_head[32];
    assign h1_pop = d1_pop && d1_head[32];

    complex_split_fifo #(.WIDTH(33), .SIZE(DATA_FIFO_SIZE)) u_d0 (
        .clk(clk), .reset_n(reset_n),
        .push(in_push), .push_data({i_tlast, i_tdata[31:16], 16'h0}),
        .pop(d0_pop), .head(d0_head), .empty(d0_empty), .full(d0_full)
    );

    complex_split_fifo #(.WIDTH(33), .SIZE(DATA_FIFO_SIZE)) u_d1 (
        .clk(clk), .reset_n(reset_n),
        .push(in_push), .push_data({i_tlast, i_tdata[15:0], 16'h0}),
        .pop(d1_pop), .head(d1_head), .empty(d1_empty), .full(d1_full)
    );

    complex_split_fifo #(.WIDTH(96), .SIZE(HDR_FIFO_SIZE)) u_h0 (
        .clk(clk), .reset_n(reset_n),
        .push(hdr_push), .push_data(hdr_word),
        .pop(h0_pop), .head(h0_head), .empty(h0_empty), .full(h0_full)
    );

    complex_split_fifo #(.WIDTH(96), .SIZE(HDR_FIFO_SIZE)) u_h1 (
        .clk(clk), .reset_n(reset_n),
        .push(hdr_push), .push_data(hdr_word),
        .pop(h1_pop), .head(h1_head), .empty(h1_empty), .full(h1_full)
    );

    assign o0_tvalid = !d0_empty;
    assign o0_tdata  = d0_head[31:0];
    assign o0_tlast  = d0_head[32];
    assign o0_tuser  = {h0_head[95:64], src_sid0, next_dst_sid0, h0_head[63:0]};

    assign o1_tvalid = !d1_empty;
    assign o1_tdata  = d1_head[31:0];
    assign o1_tlast  = d1_head[32];
    assign o1_tuser  = {h1_head[95:64], src_sid1, next_dst_sid1, h1_head[63:0]};

    a_hdr0_present: assert property (@(posedge clk) disable iff (!reset_n) !d0_empty |-> !h0_empty);
    a_hdr1_present: assert property (@(posedge clk) disable iff (!reset_n) !d1_empty |-> !h1_empty);
endmodule
